// File: rtl/renamer_n_pkg.sv
// renamer_n_pkg: shared types and constants for the register-renaming stage.
package renamer_n_pkg;

  localparam int unsigned ARCH_REGS    = 32;
  localparam int unsigned RN_BITS_DEF  = 6;
  localparam int unsigned TAG_BITS_DEF = 2;

  typedef logic [4:0]              arch_reg_t;
  typedef logic [RN_BITS_DEF-1:0]  rename_idx_t;
  typedef logic [TAG_BITS_DEF-1:0] spec_tag_t;

endpackage

// File: rtl/renamer_n_free_list.sv
// rename_free_list: multi-pop/multi-push circular FIFO of rename indices,
// initialised full with 1..2^IDX_BITS-1. Popped entries are read combinationally
// from the head; pushes land at the tail and are visible from the next cycle.
module rename_free_list #(
  parameter int unsigned POP_W    = 2,
  parameter int unsigned PUSH_W   = 2,
  parameter int unsigned IDX_BITS = 6
) (
  input  logic                                clock,
  input  logic                                init,
  input  logic [$clog2(POP_W+1)-1:0]          pop_cnt,
  input  logic [PUSH_W-1:0]                   push_valid,
  input  logic [PUSH_W-1:0][IDX_BITS-1:0]     push_idx,
  output logic [POP_W-1:0][IDX_BITS-1:0]      pop_idx_c,
  output logic [IDX_BITS-1:0]                 count
);

  localparam int unsigned DEPTH = (1 << IDX_BITS) - 1;

  logic [IDX_BITS-1:0] mem_q [DEPTH];
  logic [IDX_BITS-1:0] head_q, tail_q, head_d, tail_d;
  logic [IDX_BITS:0]   cnt_q, cnt_d;
  logic [PUSH_W-1:0][IDX_BITS-1:0] push_ptr;

  function automatic logic [IDX_BITS-1:0] wrap_add(input logic [IDX_BITS-1:0] p,
                                                   input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return IDX_BITS'(s);
  endfunction

  // Pointer advance, compacted push slots and head-side read ports.
  always_comb begin
    tail_d   = tail_q;
    push_ptr = '0;
    for (int l = 0; l < PUSH_W; l++) begin
      push_ptr[l] = tail_d;
      if (push_valid[l]) tail_d = wrap_add(tail_d, 1);
    end
    for (int k = 0; k < POP_W; k++) begin
      pop_idx_c[k] = mem_q[wrap_add(head_q, k)];
    end
    head_d = wrap_add(head_q, 32'(pop_cnt));
    cnt_d  = cnt_q - (IDX_BITS+1)'(pop_cnt) + (IDX_BITS+1)'($countones(push_valid));
  end

  // Storage and pointers; init refills the list with every non-zero index.
  always_ff @(posedge clock) begin
    if (init) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= IDX_BITS'(i + 1);
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= (IDX_BITS+1)'(DEPTH);
    end else begin
      for (int l = 0; l < PUSH_W; l++) begin
        if (push_valid[l]) mem_q[push_ptr[l]] <= push_idx[l];
      end
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count = cnt_q[IDX_BITS-1:0];

  // The list can never hold more than its depth.
  count_in_range: assert property (@(posedge clock) cnt_q <= (IDX_BITS+1)'(DEPTH));

endmodule

// File: rtl/renamer_n.sv
// renamer_n: decode-to-dispatch rename stage with RAT, intra-group forwarding,
// free-list allocation and speculative branch tagging.
// Optional: define RENAMER_STATS_EN to add the stall_cycles counter output.
module renamer_n
  import renamer_n_pkg::*;
#(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned RET_WIDTH = 2,
  parameter int unsigned RN_BITS   = RN_BITS_DEF,
  parameter int unsigned TAG_BITS  = TAG_BITS_DEF
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 stop,
  input  logic                                 flush,
  input  logic [WIDTH-1:0]                     in_valid,
  input  arch_reg_t [WIDTH-1:0]                in_rs_1,
  input  arch_reg_t [WIDTH-1:0]                in_rs_2,
  input  arch_reg_t [WIDTH-1:0]                in_rd,
  input  logic [WIDTH-1:0]                     in_writes,
  input  logic [WIDTH-1:0]                     in_jumps,
  output logic                                 in_ready,
  input  logic [RET_WIDTH-1:0]                 ret_valid,
  input  arch_reg_t [RET_WIDTH-1:0]            ret_rd,
  input  logic [RET_WIDTH-1:0][RN_BITS-1:0]    ret_rn,
  output logic [WIDTH-1:0]                     out_valid,
  output logic [WIDTH-1:0][RN_BITS-1:0]        out_rs_1_rn,
  output logic [WIDTH-1:0][RN_BITS-1:0]        out_rs_2_rn,
  output logic [WIDTH-1:0][RN_BITS-1:0]        out_rd_rn,
  output logic [WIDTH-1:0][TAG_BITS-1:0]       out_tag,
  output logic [WIDTH-1:0]                     out_jump_mask,
  output logic [RN_BITS-1:0]                   free_count
`ifdef RENAMER_STATS_EN
  ,
  output logic [31:0]                          stall_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [RN_BITS-1:0] rat_q [ARCH_REGS];
  logic [RN_BITS-1:0] rat_d [ARCH_REGS];
  logic [TAG_BITS-1:0] tag_cnt_q, tag_sum;

  logic [WIDTH-1:0]                writer, jump_v;
  logic [WIDTH-1:0][CNT_W-1:0]     rank;
  logic [CNT_W-1:0]                need, pop_cnt;
  logic [WIDTH-1:0][RN_BITS-1:0]   pop_idx_c, alloc_idx, rs1_map, rs2_map;
  logic [WIDTH-1:0][TAG_BITS-1:0]  tag_map;
  logic                            accept;

  // Writer detection, allocation ranks, tags and forwarded source lookup.
  always_comb begin
    writer    = '0;
    jump_v    = in_valid & in_jumps;
    rank      = '0;
    need      = '0;
    tag_sum   = tag_cnt_q;
    tag_map   = '0;
    alloc_idx = '0;
    rs1_map   = '0;
    rs2_map   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      writer[i] = in_valid[i] & in_writes[i] & (in_rd[i] != '0);
      rank[i]   = need;
      for (int k = 0; k < WIDTH; k++) begin
        if (writer[i] && rank[i] == CNT_W'(k)) alloc_idx[i] = pop_idx_c[k];
      end
      if (in_valid[i]) begin
        tag_map[i] = tag_sum;
        rs1_map[i] = (in_rs_1[i] == '0) ? '0 : rat_q[in_rs_1[i]];
        rs2_map[i] = (in_rs_2[i] == '0) ? '0 : rat_q[in_rs_2[i]];
        for (int j = 0; j < i; j++) begin
          if (writer[j] && in_rd[j] == in_rs_1[i]) rs1_map[i] = alloc_idx[j];
          if (writer[j] && in_rd[j] == in_rs_2[i]) rs2_map[i] = alloc_idx[j];
        end
      end
      need    = need + CNT_W'(writer[i]);
      tag_sum = tag_sum + TAG_BITS'(jump_v[i]);
    end
    accept  = !stop && !flush && !reset && (free_count >= RN_BITS'(need));
    pop_cnt = accept ? need : '0;
  end

  assign in_ready = accept;

  // Next RAT: retire clears first, then allocations so a same-cycle write wins.
  always_comb begin
    rat_d = rat_q;
    for (int l = 0; l < RET_WIDTH; l++) begin
      if (ret_valid[l] && rat_q[ret_rd[l]] == ret_rn[l]) rat_d[ret_rd[l]] = '0;
    end
    if (accept) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (writer[i]) rat_d[in_rd[i]] = alloc_idx[i];
      end
    end
  end

  // RAT, tag counter and registered outputs; flush/reset dominate.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int r = 0; r < ARCH_REGS; r++) rat_q[r] <= '0;
      tag_cnt_q     <= '0;
      out_valid     <= '0;
      out_rs_1_rn   <= '0;
      out_rs_2_rn   <= '0;
      out_rd_rn     <= '0;
      out_tag       <= '0;
      out_jump_mask <= '0;
    end else begin
      rat_q <= rat_d;
      if (accept) begin
        tag_cnt_q     <= tag_sum;
        out_valid     <= in_valid;
        out_rs_1_rn   <= rs1_map;
        out_rs_2_rn   <= rs2_map;
        out_rd_rn     <= alloc_idx;
        out_tag       <= tag_map;
        out_jump_mask <= jump_v;
      end else if (!stop) begin
        out_valid <= '0;
      end
    end
  end

  rename_free_list #(
    .POP_W    (WIDTH),
    .PUSH_W   (RET_WIDTH),
    .IDX_BITS (RN_BITS)
  ) u_free_list (
    .clock      (clock),
    .init       (reset || flush),
    .pop_cnt    (pop_cnt),
    .push_valid (ret_valid),
    .push_idx   (ret_rn),
    .pop_idx_c  (pop_idx_c),
    .count      (free_count)
  );

`ifdef RENAMER_STATS_EN
  // Saturating count of cycles where a presented group was refused without stop.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      stall_cycles <= '0;
    end else if ((|in_valid) && !in_ready && !stop && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_renamer_n.sv
// tb_renamer_n: directed scenarios followed by random traffic, all checked
// against a sequential queue-based reference model of the rename stage.
module tb_renamer_n;
  import renamer_n_pkg::*;

  localparam int unsigned WIDTH = 2, RET_WIDTH = 2, RN_BITS = 6, TAG_BITS = 2;
  localparam int DEPTH = (1 << RN_BITS) - 1;

  logic clock = 1'b0;
  logic reset, stop, flush;
  logic [WIDTH-1:0] in_valid, in_writes, in_jumps;
  arch_reg_t [WIDTH-1:0] in_rs_1, in_rs_2, in_rd;
  logic in_ready;
  logic [RET_WIDTH-1:0] ret_valid;
  arch_reg_t [RET_WIDTH-1:0] ret_rd;
  logic [RET_WIDTH-1:0][RN_BITS-1:0] ret_rn;
  logic [WIDTH-1:0] out_valid, out_jump_mask;
  logic [WIDTH-1:0][RN_BITS-1:0] out_rs_1_rn, out_rs_2_rn, out_rd_rn;
  logic [WIDTH-1:0][TAG_BITS-1:0] out_tag;
  logic [RN_BITS-1:0] free_count;
`ifdef RENAMER_STATS_EN
  logic [31:0] stall_cycles;
`endif

  renamer_n #(.WIDTH(WIDTH), .RET_WIDTH(RET_WIDTH), .RN_BITS(RN_BITS), .TAG_BITS(TAG_BITS)) dut (
    .clock(clock), .reset(reset), .stop(stop), .flush(flush),
    .in_valid(in_valid), .in_rs_1(in_rs_1), .in_rs_2(in_rs_2), .in_rd(in_rd),
    .in_writes(in_writes), .in_jumps(in_jumps), .in_ready(in_ready),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_rn(ret_rn),
    .out_valid(out_valid), .out_rs_1_rn(out_rs_1_rn), .out_rs_2_rn(out_rs_2_rn),
    .out_rd_rn(out_rd_rn), .out_tag(out_tag), .out_jump_mask(out_jump_mask),
    .free_count(free_count)
`ifdef RENAMER_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  // Reference model state
  int m_rat[32];
  int m_fl[$];
  int m_tag;
  int fl_rd[$], fl_rn[$];
  int e_valid[WIDTH], e_rs1[WIDTH], e_rs2[WIDTH], e_rd[WIDTH], e_tag[WIDTH], e_jm[WIDTH];
  longint e_stall;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_need();
    int n = 0;
    for (int i = 0; i < WIDTH; i++)
      if (in_valid[i] && in_writes[i] && in_rd[i] != 0) n++;
    return n;
  endfunction

  function automatic bit model_ready();
    return !stop && !flush && !reset && (m_fl.size() >= model_need());
  endfunction

  // One clock of the rename stage executed slot by slot, as a program would.
  task automatic model_apply();
    bit acc;
    int old_rat[32];
    bit hit[32];
    int t, rn;
    acc = model_ready();
    if (reset || flush) begin
      foreach (m_rat[r]) m_rat[r] = 0;
      m_fl.delete();
      for (int k = 1; k <= DEPTH; k++) m_fl.push_back(k);
      m_tag = 0;
      fl_rd.delete(); fl_rn.delete();
      for (int i = 0; i < WIDTH; i++) begin
        e_valid[i] = 0; e_rs1[i] = 0; e_rs2[i] = 0; e_rd[i] = 0; e_tag[i] = 0; e_jm[i] = 0;
      end
      e_stall = 0;
      return;
    end
    if (in_valid != 0 && !acc && !stop && e_stall != 64'hFFFF_FFFF) e_stall++;
    old_rat = m_rat;
    foreach (hit[r]) hit[r] = 0;
    if (acc) begin
      t = m_tag;
      for (int i = 0; i < WIDTH; i++) begin
        e_valid[i] = in_valid[i];
        if (in_valid[i]) begin
          e_rs1[i] = (in_rs_1[i] == 0) ? 0 : m_rat[in_rs_1[i]];
          e_rs2[i] = (in_rs_2[i] == 0) ? 0 : m_rat[in_rs_2[i]];
          e_tag[i] = t;
          e_jm[i]  = in_jumps[i];
          if (in_jumps[i]) t = (t + 1) % (1 << TAG_BITS);
          if (in_writes[i] && in_rd[i] != 0) begin
            rn = m_fl.pop_front();
            m_rat[in_rd[i]] = rn;
            hit[in_rd[i]] = 1;
            e_rd[i] = rn;
            fl_rd.push_back(in_rd[i]); fl_rn.push_back(rn);
          end else e_rd[i] = 0;
        end else begin
          e_rs1[i] = 0; e_rs2[i] = 0; e_rd[i] = 0; e_tag[i] = 0; e_jm[i] = 0;
        end
      end
      m_tag = t;
    end else if (!stop) begin
      for (int i = 0; i < WIDTH; i++) e_valid[i] = 0;
    end
    for (int l = 0; l < RET_WIDTH; l++) begin
      if (ret_valid[l]) begin
        if (old_rat[ret_rd[l]] == int'(ret_rn[l]) && !hit[ret_rd[l]]) m_rat[ret_rd[l]] = 0;
        m_fl.push_back(int'(ret_rn[l]));
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < WIDTH; i++) begin
      chk($sformatf("out_valid[%0d]", i), out_valid[i], e_valid[i]);
      chk($sformatf("out_rs_1_rn[%0d]", i), out_rs_1_rn[i], e_rs1[i]);
      chk($sformatf("out_rs_2_rn[%0d]", i), out_rs_2_rn[i], e_rs2[i]);
      chk($sformatf("out_rd_rn[%0d]", i), out_rd_rn[i], e_rd[i]);
      chk($sformatf("out_tag[%0d]", i), out_tag[i], e_tag[i]);
      chk($sformatf("out_jump_mask[%0d]", i), out_jump_mask[i], e_jm[i]);
    end
    chk("free_count", free_count, m_fl.size());
`ifdef RENAMER_STATS_EN
    chk("stall_cycles", stall_cycles, e_stall);
`endif
  endtask

  task automatic tick();
    @(negedge clock);
    chk("in_ready", in_ready, model_ready());
    model_apply();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic clear_in();
    in_valid = '0; in_writes = '0; in_jumps = '0;
    in_rs_1 = '0; in_rs_2 = '0; in_rd = '0;
    ret_valid = '0; ret_rd = '0; ret_rn = '0;
  endtask

  task automatic set_slot(input int i, input bit v, input int rd, input int rs1, input int rs2,
                          input bit w, input bit j);
    in_valid[i] = v; in_rd[i] = 5'(rd); in_rs_1[i] = 5'(rs1); in_rs_2[i] = 5'(rs2);
    in_writes[i] = w; in_jumps[i] = j;
  endtask

  // Retire one in-flight allocation (chosen by position) on a lane.
  task automatic retire_at(input int lane, input int idx);
    ret_valid[lane] = 1'b1;
    ret_rd[lane] = 5'(fl_rd[idx]);
    ret_rn[lane] = RN_BITS'(fl_rn[idx]);
    fl_rd.delete(idx); fl_rn.delete(idx);
  endtask

  initial begin
    clear_in();
    stop = 0; flush = 0; reset = 1;
    tick(); tick();
    reset = 0;
    chk("reset free_count", free_count, 63);
    chk("reset out_valid", out_valid, 0);

    // Two dependent writers in one group
    set_slot(0, 1, 5, 1, 2, 1, 0);
    set_slot(1, 1, 6, 5, 3, 1, 0);
    tick();
    chk("t1 rd0", out_rd_rn[0], 1);
    chk("t1 rd1", out_rd_rn[1], 2);
    chk("t1 fwd rs1", out_rs_1_rn[1], 1);
    chk("t1 free_count", free_count, 61);

    // Retire (x5, rn 1) clears the mapping
    clear_in();
    retire_at(0, 0);
    tick();
    chk("t2 free_count", free_count, 62);
    clear_in();
    set_slot(0, 1, 0, 5, 6, 0, 0);
    tick();
    chk("t2 x5 arch", out_rs_1_rn[0], 0);
    chk("t2 x6 renamed", out_rs_2_rn[0], 2);

    // Drain to one entry, then a two-writer group must wait
    for (int n = 0; n < 40 && m_fl.size() > 1; n++) begin
      bit two;
      two = (m_fl.size() >= 3);
      clear_in();
      set_slot(0, 1, 7, 0, 0, 1, 0);
      set_slot(1, 1, 8, 7, 0, two, 0);
      tick();
    end
    chk("t3 drained", free_count, 1);
    clear_in();
    set_slot(0, 1, 9, 0, 0, 1, 0);
    set_slot(1, 1, 10, 0, 0, 1, 0);
    #1;
    chk("t3 ready low", in_ready, 0);
    tick();
    chk("t3 bubble", out_valid, 0);
    retire_at(0, 0);
    tick();
    ret_valid = '0;
    #1;
    chk("t3 ready high", in_ready, 1);
    tick();
    chk("t3 accepted", out_valid, 3);
    chk("t3 empty", free_count, 0);

    // Tags wrap: bring tag_cnt to 3, then jumps in both slots
    clear_in();
    set_slot(0, 1, 0, 0, 0, 0, 1);
    tick(); tick(); tick();
    set_slot(1, 1, 0, 0, 0, 0, 1);
    tick();
    chk("t4 tag0", out_tag[0], 3);
    chk("t4 tag1", out_tag[1], 0);
    chk("t4 jump mask", out_jump_mask, 3);
    clear_in();
    set_slot(0, 1, 0, 0, 0, 0, 0);
    tick();
    chk("t4 tag after", out_tag[0], 1);

    // Stop for three cycles with a retire in the first
    stop = 1;
    set_slot(0, 1, 12, 0, 0, 1, 0);
    set_slot(1, 1, 13, 0, 0, 1, 0);
    retire_at(0, 0);
    tick();
    ret_valid = '0;
    tick(); tick();
    chk("t5 hold valid", out_valid[0], 1);
    chk("t5 hold tag", out_tag[0], 1);
    chk("t5 free_count", free_count, 1);
    stop = 0;

    // Flush beats accept and retire
    clear_in();
    set_slot(0, 1, 11, 0, 0, 1, 0);
    retire_at(0, 0);
    flush = 1;
    tick();
    flush = 0;
    chk("t6 free_count", free_count, 63);
    chk("t6 out_valid", out_valid, 0);
    clear_in();
    set_slot(0, 1, 0, 7, 8, 0, 0);
    set_slot(1, 1, 0, 9, 10, 0, 0);
    tick();
    chk("t6 rat0a", out_rs_1_rn[0], 0);
    chk("t6 rat0b", out_rs_2_rn[1], 0);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      clear_in();
      for (int i = 0; i < WIDTH; i++)
        set_slot(i, $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      for (int l = 0; l < RET_WIDTH; l++)
        if (fl_rn.size() > 0 && $urandom_range(0, 2) != 0)
          retire_at(l, $urandom_range(0, fl_rn.size() - 1));
      stop  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 63) == 0);
      reset = ($urandom_range(0, 255) == 0);
      tick();
    end
    reset = 0; flush = 0; stop = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
